uart_tx_arb: RTL and testbench

Round-robin arbiter that shares the single `uart` transmit path between N_REQ byte-stream clients.
- It grants the path to one client for a burst that ends on that client's last byte or a burst-length cap.
- While a client holds the grant, the block forwards its bytes to uart `i_we`/`i_data`, paced by uart `o_mty`.
- It sits between on-chip producers and the `uart` instance. `o_we` connects to uart `i_we`, `o_data` to uart `i_data`, and uart `o_mty` to `i_mty`.

---
 rtl/uart_tx_arb.sv | 129 ++++++++++++
 tb/tb_uart_tx_arb.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one uart transmit path among
// N_REQ byte-stream clients. A grant lasts for one burst, which ends on the
// client's last byte, after MAX_BURST bytes, or when the client drops its
// request. Bytes are forwarded to the uart only while it reports empty.
//
// Ports:
//   i_clk   system clock, rising edge
//   i_nrst  asynchronous active-low reset
//   i_req   per-client request, held while the client has bytes to send
//   i_data  per-client byte, client k at [k*WIDTH_DATA +: WIDTH_DATA]
//   i_last  per-client flag marking the final byte of a packet
//   o_gnt   registered one-hot grant
//   o_ack   one-cycle pulse to the granted client when its byte is taken
//   o_we    write strobe to uart i_we
//   o_data  byte to uart i_data (zero when no grant is held)
//   i_mty   uart o_mty; high when the uart can take a byte this cycle
module uart_tx_arb #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned WIDTH_DATA = 8,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                        i_clk,
  input  logic                        i_nrst,
  input  logic [N_REQ-1:0]            i_req,
  input  logic [N_REQ*WIDTH_DATA-1:0] i_data,
  input  logic [N_REQ-1:0]            i_last,
  output logic [N_REQ-1:0]            o_gnt,
  output logic [N_REQ-1:0]            o_ack,
  output logic                        o_we,
  output logic [WIDTH_DATA-1:0]       o_data,
  input  logic                        i_mty
);

  localparam int unsigned SW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_CAP  = CW'(MAX_BURST - 1);
  localparam logic [SW-1:0] LAST_IDX = SW'(N_REQ - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state;
  logic [SW-1:0]         sel;
  logic [SW-1:0]         rr_ptr;
  logic [CW-1:0]         count;
  logic [SW-1:0]         pick;
  logic                  pick_vld;
  logic                  busy;
  logic                  sel_req;
  logic                  sel_last;
  logic [WIDTH_DATA-1:0] sel_data;
  logic [WIDTH_DATA-1:0] data_arr [N_REQ];

  always_comb begin : unpack_data
    for (int unsigned k = 0; k < N_REQ; k++) begin
      data_arr[k] = i_data[k*WIDTH_DATA +: WIDTH_DATA];
    end
  end

  // First requester at or above rr_ptr, wrapping past N_REQ-1 back to 0.
  always_comb begin : rr_search
    int unsigned idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!pick_vld && i_req[SW'(idx)]) begin
        pick     = SW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign busy     = (state == BUSY);
  assign sel_req  = i_req[sel];
  assign sel_last = i_last[sel];
  assign sel_data = data_arr[sel];

  assign o_we   = busy & i_mty & sel_req;
  assign o_data = busy ? sel_data : '0;

  always_comb begin : ack_decode
    o_ack = '0;
    if (o_we) begin
      o_ack[sel] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state  <= IDLE;
      o_gnt  <= '0;
      sel    <= '0;
      rr_ptr <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state <= BUSY;
            sel   <= pick;
            o_gnt <= N_REQ'(1) << pick;
            count <= '0;
          end
        end
        BUSY: begin
          // Abort (request dropped) releases without a transfer; otherwise a
          // transfer releases on the last byte or when the burst cap is hit.
          if (!sel_req || (i_mty && (sel_last || count == CNT_CAP))) begin
            state  <= IDLE;
            o_gnt  <= '0;
            count  <= '0;
            rr_ptr <= (sel == LAST_IDX) ? '0 : sel + SW'(1);
          end else if (i_mty) begin
            count <= count + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          o_gnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 16;
  localparam int QD = 64;

  logic           clk = 1'b0;
  logic           nrst;
  logic [N-1:0]   req, last, gnt, ack;
  logic [N*W-1:0] data;
  logic           we, mty;
  logic [W-1:0]   odata;

  uart_tx_arb #(.N_REQ(N), .WIDTH_DATA(W), .MAX_BURST(MB)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_req(req), .i_data(data), .i_last(last),
    .o_gnt(gnt), .o_ack(ack), .o_we(we), .o_data(odata), .i_mty(mty)
  );

  always #5 clk = ~clk;

  // Client byte queues (circular), entry = {last, byte}
  logic [W:0] qm [N][QD];
  int hd [N];
  int tl [N];
  bit hold [N];

  // Reference model: current owner (-1 none), round-robin pointer, burst count
  int owner, mptr, mcnt;
  int checks = 0;
  int passes = 0;

  int gh[$];
  int wl_c[$], wl_d[$], wl_t[$];

  function automatic void push(int k, int b, bit l);
    qm[k][tl[k] % QD] = {l, W'(b)};
    tl[k]++;
  endfunction

  function automatic void check_eq(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  function automatic int lc(int i); return (i < wl_c.size()) ? wl_c[i] : -1; endfunction
  function automatic int ld(int i); return (i < wl_d.size()) ? wl_d[i] : -1; endfunction
  function automatic int lt(int i); return (i < wl_t.size()) ? wl_t[i] : -1; endfunction
  function automatic int ghv(int i); return (i < gh.size()) ? gh[i] : -1; endfunction

  function automatic void clear_logs();
    gh.delete(); wl_c.delete(); wl_d.delete(); wl_t.delete();
  endfunction

  function automatic void release_m();
    mptr  = (owner + 1) % N;
    owner = -1;
    mcnt  = 0;
  endfunction

  function automatic void model_edge();
    bit endp;
    if (owner < 0) begin
      for (int i = 0; i < N; i++) begin
        int c;
        c = (mptr + i) % N;
        if (owner < 0 && req[c]) begin
          owner = c;
          mcnt  = 0;
        end
      end
    end else if (!req[owner]) begin
      release_m();
    end else if (mty) begin
      endp = last[owner] || (mcnt == MB - 1);
      hd[owner]++;
      if (endp) release_m();
      else mcnt++;
    end
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req[k] = (hd[k] != tl[k]) && !hold[k];
      if (hd[k] != tl[k]) begin
        data[k*W +: W] = qm[k][hd[k] % QD][W-1:0];
        last[k]        = qm[k][hd[k] % QD][W];
      end else begin
        data[k*W +: W] = W'($urandom);
        last[k]        = 1'b0;
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] eg, ea;
    logic         ewe;
    logic [W-1:0] ed;
    int           ci;
    drive();
    @(negedge clk);
    eg = '0; ea = '0; ewe = 1'b0; ed = '0;
    if (nrst && owner >= 0) begin
      eg[owner] = 1'b1;
      ewe = mty && req[owner];
      if (ewe) ea[owner] = 1'b1;
      ed = data[owner*W +: W];
    end
    checks++;
    if (gnt === eg && ack === ea && we === ewe && odata === ed) passes++;
    else $display("FAIL cycle_outputs t=%0t: got gnt=%b ack=%b we=%b data=%h expected gnt=%b ack=%b we=%b data=%h",
                  $time, gnt, ack, we, odata, eg, ea, ewe, ed);
    gh.push_back(int'(gnt));
    if (we === 1'b1) begin
      ci = -1;
      for (int k = 0; k < N; k++) if (ack[k]) ci = k;
      wl_c.push_back(ci);
      wl_d.push_back(int'(odata));
      wl_t.push_back(gh.size() - 1);
    end
    @(posedge clk);
    if (nrst) model_edge();
    #1;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    owner = -1; mptr = 0; mcnt = 0;
    for (int k = 0; k < N; k++) begin hd[k] = 0; tl[k] = 0; hold[k] = 0; end
    mty = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  function automatic int pending();
    int p;
    p = (owner >= 0) ? 1 : 0;
    for (int k = 0; k < N; k++) p += tl[k] - hd[k];
    return p;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int n1;
    // Async reset: outputs must be zero before any clock edge
    nrst = 1'b0; mty = 1'b1;
    owner = -1; mptr = 0; mcnt = 0;
    for (int k = 0; k < N; k++) begin hd[k] = 0; tl[k] = 0; hold[k] = 0; end
    push(0, 'h11, 1);
    drive();
    #1;
    check_eq("rst_gnt", 32'(gnt), 0);
    check_eq("rst_we", 32'(we), 0);
    check_eq("rst_ack", 32'(ack), 0);
    check_eq("rst_data", 32'(odata), 0);

    // 1: single client, normal packet
    do_reset();
    clear_logs(); mty = 1'b1;
    push(0, 'hA5, 0); push(0, 'h5A, 0); push(0, 'h3C, 1);
    run(6);
    check_eq("t1_gnt0", ghv(0), 0);
    check_eq("t1_gnt1", ghv(1), 1);
    check_eq("t1_nwr", wl_d.size(), 3);
    check_eq("t1_d0", ld(0), 'hA5); check_eq("t1_t0", lt(0), 1);
    check_eq("t1_d1", ld(1), 'h5A); check_eq("t1_t1", lt(1), 2);
    check_eq("t1_d2", ld(2), 'h3C); check_eq("t1_t2", lt(2), 3);
    check_eq("t1_c2", lc(2), 0);
    check_eq("t1_gnt_rel", ghv(4), 0);
    check_eq("t1_model_ptr", mptr, 1);

    // 2: all clients contend, client 0 re-requests
    do_reset();
    clear_logs(); mty = 1'b1;
    for (int k = 0; k < N; k++) push(k, 'h10 + k, 1);
    run(2);
    push(0, 'h20, 1);
    run(10);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("t2_c%0d", i), lc(i), (i == 4) ? 0 : i);
      check_eq($sformatf("t2_d%0d", i), ld(i), (i == 4) ? 'h20 : 'h10 + i);
      check_eq($sformatf("t2_t%0d", i), lt(i), 2 * i + 1);
    end
    for (int i = 1; i <= 4; i++) check_eq($sformatf("t2_gap%0d", i), ghv(2 * i), 0);

    // 3: backpressure on client 2
    clear_logs(); mty = 1'b1;
    push(2, 'hC0, 0); push(2, 'hC1, 0); push(2, 'hC2, 0); push(2, 'hC3, 1);
    run(3);
    mty = 1'b0;
    run(5);
    mty = 1'b1;
    run(3);
    check_eq("t3_nwr", wl_d.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t3_d%0d", i), ld(i), 'hC0 + i);
      check_eq($sformatf("t3_t%0d", i), lt(i), (i < 2) ? i + 1 : i + 6);
    end
    for (int i = 3; i <= 7; i++) check_eq($sformatf("t3_hold%0d", i), ghv(i), 4);
    check_eq("t3_rel", ghv(10), 0);

    // 4: burst cap
    do_reset();
    clear_logs(); mty = 1'b1;
    for (int i = 0; i < 20; i++) push(1, 'h40 + i, 0);
    push(2, 'h80, 0); push(2, 'h81, 1);
    run(28);
    n1 = 0;
    for (int i = 0; i < wl_c.size(); i++) if (wl_c[i] == 1 && wl_t[i] < 17) n1++;
    check_eq("t4_first_burst", n1, 16);
    check_eq("t4_c16", lc(16), 2); check_eq("t4_t16", lt(16), 18);
    check_eq("t4_d17", ld(17), 'h81);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t4_rem_c%0d", i), lc(18 + i), 1);
      check_eq($sformatf("t4_rem_d%0d", i), ld(18 + i), 'h50 + i);
      check_eq($sformatf("t4_rem_t%0d", i), lt(18 + i), 21 + i);
    end
    check_eq("t4_nwr", wl_d.size(), 22);

    // 5: abort by client 3
    clear_logs();
    push(3, 'hD0, 0); push(3, 'hD1, 0); push(3, 'hD2, 1);
    run(2);
    hold[3] = 1;
    run(2);
    check_eq("t5_nwr", wl_d.size(), 1);
    check_eq("t5_d0", ld(0), 'hD0);
    check_eq("t5_gnt_held", ghv(2), 8);
    check_eq("t5_gnt_rel", ghv(3), 0);
    check_eq("t5_model_ptr", mptr, 0);
    hold[3] = 0; hd[3] = tl[3];

    // 6: reset mid-burst
    clear_logs();
    for (int i = 0; i < 5; i++) push(1, 'hE0 + i, i == 4);
    run(3);
    drive();
    #1;
    check_eq("t6_we_pre", 32'(we), 1);
    nrst = 1'b0;
    owner = -1; mptr = 0; mcnt = 0;
    #1;
    check_eq("t6_gnt_async", 32'(gnt), 0);
    check_eq("t6_we_async", 32'(we), 0);
    check_eq("t6_ack_async", 32'(ack), 0);
    push(3, 'hF0, 1);
    run(2);
    nrst = 1'b1;
    clear_logs();
    run(8);
    check_eq("t6_c0", lc(0), 1); check_eq("t6_d0", ld(0), 'hE2); check_eq("t6_t0", lt(0), 1);
    check_eq("t6_c3", lc(3), 3); check_eq("t6_t3", lt(3), 5);

    // Randomized traffic against the model
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int k = 0; k < N; k++) begin
        if (tl[k] - hd[k] < 8 && $urandom_range(0, 7) == 0) begin
          int len;
          len = $urandom_range(1, 24);
          for (int i = 0; i < len; i++)
            push(k, int'($urandom_range(0, 255)), (i == len - 1) ? ($urandom_range(0, 5) != 0) : 1'b0);
        end
        hold[k] = ($urandom_range(0, 19) == 0);
      end
      mty = ($urandom_range(0, 3) != 0);
      step();
    end
    mty = 1'b1;
    for (int k = 0; k < N; k++) hold[k] = 0;
    guard = 0;
    while (pending() != 0 && guard < 3000) begin
      step();
      guard++;
    end
    check_eq("drain_empty", pending(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
